// File: rtl/stack_seq_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the stack operation sequencer.
// Optional feature: define STACK_SEQ_MUL_EN to turn opcode 7 into MUL (otherwise NOP).
package stack_seq_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 256;

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_POP  = 3'd1;
   localparam logic [2:0] OP_TOP  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_MUL  = 3'd7;

`ifdef STACK_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      POP_A,
      POP_B,
      TOS,
      CALC,
      PUSH_R,
      ERR
   } state_t;

   // Two-operand opcodes: these pop twice before the ALU step.
   function automatic logic is_binary(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (MUL_EN && (op == OP_MUL));
   endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational ALU for the stack sequencer; a is the former top of stack, b the entry below.
// MUL is only present when STACK_SEQ_MUL_EN is defined.
module stack_seq_alu
   import stack_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = b + a;
         OP_SUB:  y = b - a;
         OP_AND:  y = b & a;
         OP_NOT:  y = ~a;
`ifdef STACK_SEQ_MUL_EN
         OP_MUL:  y = b * a;
`endif
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/stack_op_sequencer.sv
// Command sequencer driving an external registered-read stack through push/pop/tos strobes.
// Define STACK_SEQ_MUL_EN to enable opcode 7 as MUL; the default build treats it as NOP.
module stack_op_sequencer
   import stack_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              stk_push,
   output logic              stk_pop,
   output logic              stk_tos,
   output logic [DATA_W-1:0] stk_din,
   input  logic [DATA_W-1:0] stk_dout,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              err_under,
   output logic              err_over,
   output logic [8:0]        depth
);

   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] res_q;
   logic              err_over_q;
   logic [8:0]        depth_q;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_y;
   logic [DATA_W-1:0] push_val;
   logic              pass_thru;

   // NOT has only one operand, taken straight from the stack read port.
   assign alu_a     = (op_q == OP_NOT) ? stk_dout : a_q;
   assign pass_thru = (op_q == OP_POP) || (op_q == OP_TOP);
   assign push_val  = (op_q == OP_PUSH) ? imm_q : res_q;
   assign depth     = depth_q;

   stack_seq_alu #(.DATA_W(DATA_W)) u_alu (
      .op (op_q),
      .a  (alu_a),
      .b  (stk_dout),
      .y  (alu_y)
   );

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_tos   = 1'b0;
      stk_din   = push_val;
      res_valid = 1'b0;
      res_data  = res_q;
      err_under = 1'b0;
      err_over  = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH:        state_d = (depth_q < DEPTH_L) ? PUSH_R : ERR;
                  OP_POP, OP_NOT: state_d = (depth_q >= 9'd1) ? POP_A : ERR;
                  OP_TOP:         state_d = (depth_q >= 9'd1) ? TOS : ERR;
                  default: begin
                     if (is_binary(cmd_op))
                        state_d = (depth_q >= 9'd2) ? POP_A : ERR;
                     else
                        state_d = IDLE;
                  end
               endcase
            end
         end
         POP_A: begin
            stk_pop = 1'b1;
            state_d = is_binary(op_q) ? POP_B : CALC;
         end
         POP_B: begin
            stk_pop = 1'b1;
            state_d = CALC;
         end
         TOS: begin
            stk_tos = 1'b1;
            state_d = CALC;
         end
         CALC: begin
            if (pass_thru) begin
               res_valid = 1'b1;
               res_data  = stk_dout;
               state_d   = IDLE;
            end else begin
               state_d   = PUSH_R;
            end
         end
         PUSH_R: begin
            stk_push  = 1'b1;
            res_valid = 1'b1;
            res_data  = push_val;
            state_d   = IDLE;
         end
         ERR: begin
            err_over  = err_over_q;
            err_under = !err_over_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         imm_q      <= '0;
         a_q        <= '0;
         res_q      <= '0;
         err_over_q <= 1'b0;
         depth_q    <= '0;
      end else begin
         state_q <= state_d;
         if (cmd_ready && cmd_valid) begin
            op_q       <= cmd_op;
            imm_q      <= cmd_imm;
            err_over_q <= (cmd_op == OP_PUSH);
         end
         if (state_q == POP_B)
            a_q <= stk_dout;
         if (state_q == CALC)
            res_q <= pass_thru ? stk_dout : alu_y;
         if (state_q == PUSH_R)
            res_q <= push_val;
         if (stk_push)
            depth_q <= depth_q + 9'd1;
         else if (stk_pop)
            depth_q <= depth_q - 9'd1;
      end
   end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural registered-read stack model.
// Build with STACK_SEQ_MUL_EN defined to exercise opcode 7 as MUL.
module tb_stack_op_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_imm;
   logic       stk_push, stk_pop, stk_tos;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;
   logic       res_valid;
   logic [7:0] res_data;
   logic       err_under, err_over;
   logic [8:0] depth;

   stack_op_sequencer #(.DATA_W(8), .DEPTH(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_imm   (cmd_imm),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_tos   (stk_tos),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .res_valid (res_valid),
      .res_data  (res_data),
      .err_under (err_under),
      .err_over  (err_over),
      .depth     (depth)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stack model: registered read data, reset together with the sequencer.
   logic [7:0] mem [0:255];
   int         sp;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp       <= 0;
         stk_dout <= 8'h00;
      end else if (stk_push) begin
         mem[8'(sp)] <= stk_din;
         sp          <= sp + 1;
      end else if (stk_pop) begin
         stk_dout <= mem[8'(sp - 1)];
         sp       <= sp - 1;
      end else if (stk_tos) begin
         stk_dout <= mem[8'(sp - 1)];
      end
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] imm;
      int         ready;     // first cycle after accept with cmd_ready high
      int         res_cyc;   // cycle of res_valid, 0 = none
      int         res;
      int         err;       // 0 none, 1 under, 2 over
      int         push;
      int         pop;
      int         tos;
      int         push_cyc;  // cycle of stk_push, 0 = none
      int         din;
      int         dep;
   } vec_t;

   vec_t tbl[$];
   int   passed = 0;
   int   total  = 0;
   int   last_res = 0;

   int o_ready, o_resn, o_res_cyc, o_res, o_erru, o_erro, o_err_cyc;
   int o_push, o_pop, o_tos, o_push_cyc, o_din, o_multi, o_depth, o_hold;

   function automatic vec_t mk(input logic [2:0] op, input logic [7:0] imm, input int ready,
                               input int res_cyc, input int res, input int err, input int push,
                               input int pop, input int tos, input int push_cyc, input int din,
                               input int dep);
      vec_t v;
      v.op = op; v.imm = imm; v.ready = ready; v.res_cyc = res_cyc; v.res = res;
      v.err = err; v.push = push; v.pop = pop; v.tos = tos; v.push_cyc = push_cyc;
      v.din = din; v.dep = dep;
      return v;
   endfunction

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp)
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
      else
         passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and record eight cycles of DUT activity after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [7:0] imm);
      cmd_op = op; cmd_imm = imm; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      o_ready = 0; o_resn = 0; o_res_cyc = 0; o_res = 0; o_erru = 0; o_erro = 0;
      o_err_cyc = 0; o_push = 0; o_pop = 0; o_tos = 0; o_push_cyc = 0; o_din = 0; o_multi = 0;
      for (int c = 1; c <= 8; c++) begin
         if (cmd_ready && o_ready == 0) o_ready = c;
         if (stk_push) begin
            o_push++;
            if (o_push_cyc == 0) begin o_push_cyc = c; o_din = stk_din; end
         end
         if (stk_pop) o_pop++;
         if (stk_tos) o_tos++;
         if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) o_multi++;
         if (res_valid) begin o_resn++; o_res_cyc = c; o_res = res_data; end
         if (err_under) begin o_erru++; o_err_cyc = c; end
         if (err_over) begin o_erro++; o_err_cyc = c; end
         step();
      end
      o_depth = depth;
      o_hold  = res_data;
   endtask

   task automatic check(input vec_t v, input string n);
      int hold;
      hold = (v.res_cyc != 0) ? v.res : last_res;
      chk({n, "_ready"}, o_ready, v.ready);
      chk({n, "_resn"}, o_resn, (v.res_cyc != 0) ? 1 : 0);
      if (v.res_cyc != 0) begin
         chk({n, "_res_cyc"}, o_res_cyc, v.res_cyc);
         chk({n, "_res"}, o_res, v.res);
      end
      chk({n, "_err_under"}, o_erru, (v.err == 1) ? 1 : 0);
      chk({n, "_err_over"}, o_erro, (v.err == 2) ? 1 : 0);
      if (v.err != 0) chk({n, "_err_cyc"}, o_err_cyc, 1);
      chk({n, "_push"}, o_push, v.push);
      chk({n, "_pop"}, o_pop, v.pop);
      chk({n, "_tos"}, o_tos, v.tos);
      if (v.push_cyc != 0) begin
         chk({n, "_push_cyc"}, o_push_cyc, v.push_cyc);
         chk({n, "_din"}, o_din, v.din);
      end
      chk({n, "_one_strobe"}, o_multi, 0);
      chk({n, "_depth"}, o_depth, v.dep);
      chk({n, "_hold"}, o_hold, hold);
      last_res = hold;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      last_res = 0;
   endtask

   initial begin
      vec_t v;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_strobes", int'(stk_push) + int'(stk_pop) + int'(stk_tos), 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_errs", int'(err_under) + int'(err_over), 0);
      chk("rst_depth", depth, 0);
      rst = 1'b1;
      step();

      //           op  imm   rdy rc res  err psh pop tos pc din  dep
      tbl.push_back(mk(0, 8'h05, 2, 1, 'h05, 0, 1, 0, 0, 1, 'h05, 1));
      tbl.push_back(mk(0, 8'h03, 2, 1, 'h03, 0, 1, 0, 0, 1, 'h03, 2));
      tbl.push_back(mk(4, 8'h00, 5, 4, 'h02, 0, 1, 2, 0, 4, 'h02, 1));
      tbl.push_back(mk(1, 8'h00, 3, 2, 'h02, 0, 0, 1, 0, 0, 0,    0));
      tbl.push_back(mk(3, 8'h00, 2, 0, 0,    1, 0, 0, 0, 0, 0,    0));
      tbl.push_back(mk(0, 8'hF0, 2, 1, 'hF0, 0, 1, 0, 0, 1, 'hF0, 1));
      tbl.push_back(mk(0, 8'h20, 2, 1, 'h20, 0, 1, 0, 0, 1, 'h20, 2));
      tbl.push_back(mk(3, 8'h00, 5, 4, 'h10, 0, 1, 2, 0, 4, 'h10, 1));
      tbl.push_back(mk(6, 8'h00, 4, 3, 'hEF, 0, 1, 1, 0, 3, 'hEF, 1));
      tbl.push_back(mk(2, 8'h00, 3, 2, 'hEF, 0, 0, 0, 1, 0, 0,    1));
      tbl.push_back(mk(0, 8'h3C, 2, 1, 'h3C, 0, 1, 0, 0, 1, 'h3C, 2));
      tbl.push_back(mk(5, 8'h00, 5, 4, 'h2C, 0, 1, 2, 0, 4, 'h2C, 1));
      tbl.push_back(mk(0, 8'h10, 2, 1, 'h10, 0, 1, 0, 0, 1, 'h10, 2));
      tbl.push_back(mk(0, 8'h11, 2, 1, 'h11, 0, 1, 0, 0, 1, 'h11, 3));
`ifdef STACK_SEQ_MUL_EN
      tbl.push_back(mk(7, 8'h00, 5, 4, 'h10, 0, 1, 2, 0, 4, 'h10, 2));
`else
      tbl.push_back(mk(7, 8'h00, 1, 0, 0,    0, 0, 0, 0, 0, 0,    3));
`endif

      foreach (tbl[i]) begin
         issue(tbl[i].op, tbl[i].imm);
         check(tbl[i], $sformatf("v%0d", i));
      end

      // Fill the stack completely, then overflow and read back the top.
      do_reset();
      for (int i = 0; i < 256; i++) issue(3'd0, 8'(i));
      chk("full_depth", depth, 256);
      last_res = 'hFF;
      issue(3'd0, 8'h77);
      v = mk(0, 8'h77, 2, 0, 0, 2, 0, 0, 0, 0, 0, 256);
      check(v, "over");
      issue(3'd2, 8'h00);
      v = mk(2, 8'h00, 3, 2, 'hFF, 0, 0, 0, 1, 0, 0, 256);
      check(v, "full_top");

      // Reset in the middle of an ADD.
      do_reset();
      issue(3'd0, 8'h01);
      issue(3'd0, 8'h02);
      cmd_op = 3'd3; cmd_imm = 8'h00; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      chk("mid_pop_before", stk_pop, 1);
      rst = 1'b0;
      #1;
      chk("mid_strobes", int'(stk_push) + int'(stk_pop) + int'(stk_tos), 0);
      chk("mid_depth", depth, 0);
      chk("mid_res_valid", res_valid, 0);
      chk("mid_res_data", res_data, 0);
      step();
      rst = 1'b1;
      last_res = 0;
      step();
      chk("post_ready", cmd_ready, 1);
      chk("post_depth", depth, 0);
      chk("post_strobes", int'(stk_push) + int'(stk_pop) + int'(stk_tos), 0);
      issue(3'd0, 8'h42);
      v = mk(0, 8'h42, 2, 1, 'h42, 0, 1, 0, 0, 1, 'h42, 1);
      check(v, "post_push");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
